// File: rtl/multi_book_engine.sv
// multi_book_engine
//   Order map plus NUM_BOOKS per-locate price-level books for an ITCH feed.
//   Accepts add / delete / executed messages and, after every accepted
//   message, publishes the best bid and best ask of the affected locate.
//   All storage is registers. A sequential FSM
//   (IDLE, LOOKUP, SCAN, UPDATE, BEST, PUBLISH) walks one price level per cycle.
//   The latency from the accept cycle to topValidOut is 2*BOOK_LEVELS+3 cycles.
//
// Optional build macro: MULTI_BOOK_STATS_EN
//   When this macro is defined, the block adds the saturating counters
//   msgCountOut, errCountOut and droppedCountOut.
//
// Ports
//   clkIn, rstIn          clock, synchronous active-high reset
//   addValidIn            add-order strobe
//   delValidIn            delete-order strobe
//   execValidIn           order-executed strobe
//   refNumIn              order reference number
//   locateIn              instrument locate code
//   priceIn               price (add only)
//   sharesIn              shares (add quantity / executed quantity)
//   buySellIn             side (add only), 1 = buy
//   readyOut              high in IDLE only; a message is accepted on valid & ready
//   topValidOut           one-cycle publish strobe
//   topLocateOut          locate of the published book
//   topBuyPriceOut        best bid price (0 when the buy side is empty)
//   topBuySharesOut       shares at the best bid
//   topSellPriceOut       best ask price (0 when the sell side is empty)
//   topSellSharesOut      shares at the best ask
//   errValidOut           one-cycle error strobe
//   errCodeOut            error code:
//                           1 = unknown order
//                           2 = book full
//                           3 = bad locate
//                           4 = multiple strobes
//                           5 = duplicate add
//   msgCountOut, errCountOut, droppedCountOut   (MULTI_BOOK_STATS_EN only)
module multi_book_engine #(
  parameter int NUM_BOOKS       = 4,
  parameter int BOOK_LEVELS     = 4,
  parameter int ORDER_MAP_DEPTH = 64
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        addValidIn,
  input  logic        delValidIn,
  input  logic        execValidIn,
  input  logic [63:0] refNumIn,
  input  logic [15:0] locateIn,
  input  logic [31:0] priceIn,
  input  logic [31:0] sharesIn,
  input  logic        buySellIn,
  output logic        readyOut,
  output logic        topValidOut,
  output logic [15:0] topLocateOut,
  output logic [31:0] topBuyPriceOut,
  output logic [31:0] topBuySharesOut,
  output logic [31:0] topSellPriceOut,
  output logic [31:0] topSellSharesOut,
  output logic        errValidOut,
  output logic [2:0]  errCodeOut
`ifdef MULTI_BOOK_STATS_EN
  ,
  output logic [31:0] msgCountOut,
  output logic [31:0] errCountOut,
  output logic [31:0] droppedCountOut
`endif
);

  localparam int SLOT_W = (NUM_BOOKS > 1) ? $clog2(NUM_BOOKS) : 1;
  localparam int LVL_W  = (BOOK_LEVELS > 1) ? $clog2(BOOK_LEVELS) : 1;
  localparam int IDX_W  = (ORDER_MAP_DEPTH > 1) ? $clog2(ORDER_MAP_DEPTH) : 1;
  localparam logic [15:0]      NUM_BOOKS_L = 16'(NUM_BOOKS);
  localparam logic [LVL_W-1:0] LAST_LVL    = LVL_W'(BOOK_LEVELS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_SCAN, S_UPDATE, S_BEST, S_PUBLISH
  } state_t;

  state_t r_state, w_nextState;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

  // Captured message and the map entry read at accept
  logic              r_isAdd, r_isDel;
  logic [63:0]       r_ref;
  logic [15:0]       r_loc;
  logic [31:0]       r_price, r_shares;
  logic              r_side;
  logic [IDX_W-1:0]  r_idx;
  logic              r_entValid;
  logic [63:0]       r_entRef;
  logic [15:0]       r_entLoc;
  logic [31:0]       r_entPrice, r_entShares;
  logic              r_entSide;

  // Order map
  logic [ORDER_MAP_DEPTH-1:0] r_mapValid;
  logic [63:0] r_mapRef    [ORDER_MAP_DEPTH];
  logic [15:0] r_mapLoc    [ORDER_MAP_DEPTH];
  logic [31:0] r_mapPrice  [ORDER_MAP_DEPTH];
  logic [31:0] r_mapShares [ORDER_MAP_DEPTH];
  logic        r_mapSide   [ORDER_MAP_DEPTH];

  // Books: [slot][side][level], side 1 = buy
  logic [NUM_BOOKS-1:0][1:0][BOOK_LEVELS-1:0] r_lvlValid;
  logic [31:0] r_lvlPrice  [NUM_BOOKS][2][BOOK_LEVELS];
  logic [31:0] r_lvlShares [NUM_BOOKS][2][BOOK_LEVELS];

  // Scan / best tracking
  logic [LVL_W-1:0] r_cnt;
  logic             r_matchFound, r_freeFound;
  logic [LVL_W-1:0] r_matchIdx, r_freeIdx;
  logic             r_bFound, r_sFound;
  logic [31:0]      r_bPrice, r_bShares, r_sPrice, r_sShares;

  // Registered outputs
  logic        r_errValid;
  logic [2:0]  r_errCode;
  logic [15:0] r_topLoc;
  logic [31:0] r_topBp, r_topBs, r_topSp, r_topSs;

  // Combinational helpers
  logic             w_anyValid, w_multi, w_badLoc, w_accept, w_lkErr, w_noSpace;
  logic [IDX_W-1:0] w_idxIn;
  logic [15:0]      w_ctxLoc;
  logic [31:0]      w_ctxPrice;
  logic             w_ctxSide;
  logic [SLOT_W-1:0] w_slot;
  logic             w_scV;
  logic [31:0]      w_scP;
  logic [31:0]      w_dec, w_lvlCur, w_lvlRem, w_entRem, w_addSum;
  logic             w_bV, w_sV, w_bTake, w_sTake;
  logic [31:0]      w_bP, w_bS, w_sP, w_sS;
  logic [31:0]      w_nbPrice, w_nbShares, w_nsPrice, w_nsShares;

  assign w_anyValid = addValidIn | delValidIn | execValidIn;
  assign w_multi    = (addValidIn & delValidIn) | (addValidIn & execValidIn) |
                      (delValidIn & execValidIn);
  assign w_badLoc   = (locateIn >= NUM_BOOKS_L);
  assign w_accept   = (r_state == S_IDLE) && w_anyValid;
  assign w_idxIn    = refNumIn[IDX_W-1:0];

  // Delete/exec operate on the book the resting order lives in, so the book
  // context comes from the stored entry rather than the message fields.
  assign w_ctxLoc   = r_isAdd ? r_loc   : r_entLoc;
  assign w_ctxPrice = r_isAdd ? r_price : r_entPrice;
  assign w_ctxSide  = r_isAdd ? r_side  : r_entSide;
  assign w_slot     = w_ctxLoc[SLOT_W-1:0];

  assign w_lkErr   = r_isAdd ? r_entValid : (!r_entValid || (r_entRef != r_ref));

  assign w_scV     = r_lvlValid[w_slot][w_ctxSide][r_cnt];
  assign w_scP     = r_lvlPrice[w_slot][w_ctxSide][r_cnt];

  assign w_noSpace = r_isAdd && !r_matchFound && !r_freeFound;
  // Delete removes everything the order still holds; exec is clamped so that
  // neither the entry nor the level can wrap below zero.
  assign w_dec     = r_isDel ? r_entShares : min_u32(r_shares, r_entShares);
  assign w_lvlCur  = r_lvlShares[w_slot][w_ctxSide][r_matchIdx];
  assign w_lvlRem  = w_lvlCur - w_dec;
  assign w_entRem  = r_entShares - w_dec;
  assign w_addSum  = w_lvlCur + r_shares;

  // Both sides are reduced in parallel; strict compares let the lower index win ties.
  assign w_bV       = r_lvlValid[w_slot][1'b1][r_cnt];
  assign w_bP       = r_lvlPrice[w_slot][1][r_cnt];
  assign w_bS       = r_lvlShares[w_slot][1][r_cnt];
  assign w_sV       = r_lvlValid[w_slot][1'b0][r_cnt];
  assign w_sP       = r_lvlPrice[w_slot][0][r_cnt];
  assign w_sS       = r_lvlShares[w_slot][0][r_cnt];
  assign w_bTake    = w_bV && (!r_bFound || (w_bP > r_bPrice));
  assign w_sTake    = w_sV && (!r_sFound || (w_sP < r_sPrice));
  assign w_nbPrice  = w_bTake ? w_bP : r_bPrice;
  assign w_nbShares = w_bTake ? w_bS : r_bShares;
  assign w_nsPrice  = w_sTake ? w_sP : r_sPrice;
  assign w_nsShares = w_sTake ? w_sS : r_sShares;

  always_ff @(posedge clkIn) begin
    if (rstIn) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    readyOut    = 1'b0;
    topValidOut = 1'b0;
    case (r_state)
      S_IDLE: begin
        readyOut = 1'b1;
        if (w_accept && !w_multi && !w_badLoc) w_nextState = S_LOOKUP;
      end
      S_LOOKUP:  w_nextState = w_lkErr ? S_IDLE : S_SCAN;
      S_SCAN:    if (r_cnt == LAST_LVL) w_nextState = S_UPDATE;
      S_UPDATE:  w_nextState = w_noSpace ? S_IDLE : S_BEST;
      S_BEST:    if (r_cnt == LAST_LVL) w_nextState = S_PUBLISH;
      S_PUBLISH: begin
        topValidOut = 1'b1;
        w_nextState = S_IDLE;
      end
      default:   w_nextState = S_IDLE;
    endcase
  end

  // Control: valid bits, counter, error strobe and published top-of-book
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_mapValid <= '0;
      r_lvlValid <= '0;
      r_cnt      <= '0;
      r_errValid <= 1'b0;
      r_errCode  <= '0;
      r_topLoc   <= '0;
      r_topBp    <= '0;
      r_topBs    <= '0;
      r_topSp    <= '0;
      r_topSs    <= '0;
    end else begin
      r_errValid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && (w_multi || w_badLoc)) begin
            r_errValid <= 1'b1;
            r_errCode  <= w_multi ? 3'd4 : 3'd3;
          end
        end
        S_LOOKUP: begin
          r_cnt <= '0;
          if (w_lkErr) begin
            r_errValid <= 1'b1;
            r_errCode  <= r_isAdd ? 3'd5 : 3'd1;
          end
        end
        S_SCAN: r_cnt <= (r_cnt == LAST_LVL) ? '0 : r_cnt + 1'b1;
        S_UPDATE: begin
          r_cnt <= '0;
          if (w_noSpace) begin
            r_errValid <= 1'b1;
            r_errCode  <= 3'd2;
          end else if (r_isAdd) begin
            if (!r_matchFound)
              r_lvlValid[w_slot][w_ctxSide][r_freeIdx] <= (r_shares != 32'd0);
            r_mapValid[r_idx] <= 1'b1;
          end else begin
            if (r_matchFound && (w_lvlRem == 32'd0))
              r_lvlValid[w_slot][w_ctxSide][r_matchIdx] <= 1'b0;
            if (w_entRem == 32'd0) r_mapValid[r_idx] <= 1'b0;
          end
        end
        S_BEST: begin
          r_cnt <= (r_cnt == LAST_LVL) ? '0 : r_cnt + 1'b1;
          if (r_cnt == LAST_LVL) begin
            r_topLoc <= w_ctxLoc;
            r_topBp  <= w_nbPrice;
            r_topBs  <= w_nbShares;
            r_topSp  <= w_nsPrice;
            r_topSs  <= w_nsShares;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: message capture, map/level contents, scan and best trackers
  always_ff @(posedge clkIn) begin
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          r_isAdd     <= addValidIn;
          r_isDel     <= delValidIn;
          r_ref       <= refNumIn;
          r_loc       <= locateIn;
          r_price     <= priceIn;
          r_shares    <= sharesIn;
          r_side      <= buySellIn;
          r_idx       <= w_idxIn;
          r_entValid  <= r_mapValid[w_idxIn];
          r_entRef    <= r_mapRef[w_idxIn];
          r_entLoc    <= r_mapLoc[w_idxIn];
          r_entPrice  <= r_mapPrice[w_idxIn];
          r_entShares <= r_mapShares[w_idxIn];
          r_entSide   <= r_mapSide[w_idxIn];
        end
      end
      S_LOOKUP: begin
        r_matchFound <= 1'b0;
        r_freeFound  <= 1'b0;
        r_matchIdx   <= '0;
        r_freeIdx    <= '0;
      end
      S_SCAN: begin
        if (w_scV && (w_scP == w_ctxPrice) && !r_matchFound) begin
          r_matchFound <= 1'b1;
          r_matchIdx   <= r_cnt;
        end
        if (!w_scV && !r_freeFound) begin
          r_freeFound <= 1'b1;
          r_freeIdx   <= r_cnt;
        end
      end
      S_UPDATE: begin
        r_bFound  <= 1'b0;
        r_sFound  <= 1'b0;
        r_bPrice  <= '0;
        r_bShares <= '0;
        r_sPrice  <= '0;
        r_sShares <= '0;
        if (!w_noSpace) begin
          if (r_isAdd) begin
            if (r_matchFound) begin
              r_lvlShares[w_slot][w_ctxSide][r_matchIdx] <= w_addSum;
            end else begin
              r_lvlPrice[w_slot][w_ctxSide][r_freeIdx]  <= r_price;
              r_lvlShares[w_slot][w_ctxSide][r_freeIdx] <= r_shares;
            end
            r_mapRef[r_idx]    <= r_ref;
            r_mapLoc[r_idx]    <= r_loc;
            r_mapPrice[r_idx]  <= r_price;
            r_mapShares[r_idx] <= r_shares;
            r_mapSide[r_idx]   <= r_side;
          end else begin
            if (r_matchFound) r_lvlShares[w_slot][w_ctxSide][r_matchIdx] <= w_lvlRem;
            r_mapShares[r_idx] <= w_entRem;
          end
        end
      end
      S_BEST: begin
        r_bFound  <= r_bFound | w_bV;
        r_sFound  <= r_sFound | w_sV;
        r_bPrice  <= w_nbPrice;
        r_bShares <= w_nbShares;
        r_sPrice  <= w_nsPrice;
        r_sShares <= w_nsShares;
      end
      default: ;
    endcase
  end

  assign errValidOut      = r_errValid;
  assign errCodeOut       = r_errCode;
  assign topLocateOut     = r_topLoc;
  assign topBuyPriceOut   = r_topBp;
  assign topBuySharesOut  = r_topBs;
  assign topSellPriceOut  = r_topSp;
  assign topSellSharesOut = r_topSs;

`ifdef MULTI_BOOK_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_msgCount, r_errCount, r_dropCount;

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_msgCount  <= '0;
      r_errCount  <= '0;
      r_dropCount <= '0;
    end else begin
      if (r_state == S_PUBLISH)       r_msgCount  <= sat_inc(r_msgCount);
      if (r_errValid)                 r_errCount  <= sat_inc(r_errCount);
      if (w_anyValid && !readyOut)    r_dropCount <= sat_inc(r_dropCount);
    end
  end

  assign msgCountOut     = r_msgCount;
  assign errCountOut     = r_errCount;
  assign droppedCountOut = r_dropCount;
`endif

endmodule

// File: tb/tb_multi_book_engine.sv
// Scoreboard bench for multi_book_engine: each directed message pushes its
// hand-computed publish or error (with the cycle it must appear in) and a
// negedge monitor pops and compares every DUT output strobe.
module tb_multi_book_engine;

  logic        clk = 1'b0;
  logic        rstIn;
  logic        addValidIn, delValidIn, execValidIn;
  logic [63:0] refNumIn;
  logic [15:0] locateIn;
  logic [31:0] priceIn, sharesIn;
  logic        buySellIn;
  logic        readyOut, topValidOut, errValidOut;
  logic [15:0] topLocateOut;
  logic [31:0] topBuyPriceOut, topBuySharesOut, topSellPriceOut, topSellSharesOut;
  logic [2:0]  errCodeOut;
`ifdef MULTI_BOOK_STATS_EN
  logic [31:0] msgCountOut, errCountOut, droppedCountOut;
`endif

  always #5 clk = ~clk;

  multi_book_engine dut (
    .clkIn(clk), .rstIn(rstIn),
    .addValidIn(addValidIn), .delValidIn(delValidIn), .execValidIn(execValidIn),
    .refNumIn(refNumIn), .locateIn(locateIn), .priceIn(priceIn), .sharesIn(sharesIn),
    .buySellIn(buySellIn), .readyOut(readyOut), .topValidOut(topValidOut),
    .topLocateOut(topLocateOut), .topBuyPriceOut(topBuyPriceOut),
    .topBuySharesOut(topBuySharesOut), .topSellPriceOut(topSellPriceOut),
    .topSellSharesOut(topSellSharesOut), .errValidOut(errValidOut), .errCodeOut(errCodeOut)
`ifdef MULTI_BOOK_STATS_EN
    , .msgCountOut(msgCountOut), .errCountOut(errCountOut), .droppedCountOut(droppedCountOut)
`endif
  );

  typedef struct {
    bit          isErr;
    logic [2:0]  code;
    logic [15:0] loc;
    logic [31:0] bp, bs, sp, ss;
    int          id;
    int          at;
  } exp_t;

  localparam int ADD = 0, DEL = 1, EXE = 2, ADDDEL = 3;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   next_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t pub(input logic [15:0] l, input logic [31:0] bp, input logic [31:0] bs,
                               input logic [31:0] sp, input logic [31:0] ss);
    exp_t e;
    e.isErr = 1'b0; e.code = 3'd0; e.loc = l;
    e.bp = bp; e.bs = bs; e.sp = sp; e.ss = ss; e.id = 0; e.at = 0;
    return e;
  endfunction

  function automatic exp_t erx(input logic [2:0] c);
    exp_t e;
    e.isErr = 1'b1; e.code = c; e.loc = '0;
    e.bp = '0; e.bs = '0; e.sp = '0; e.ss = '0; e.id = 0; e.at = 0;
    return e;
  endfunction

  // Output monitor
  always @(negedge clk) begin
    if (topValidOut === 1'b1 || errValidOut === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got top=%0b err=%0b code=%0d loc=%0d bid=%0d/%0d ask=%0d/%0d cyc=%0d want nothing",
                 topValidOut, errValidOut, errCodeOut, topLocateOut, topBuyPriceOut,
                 topBuySharesOut, topSellPriceOut, topSellSharesOut, cyc);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.isErr) begin
          if (!(errValidOut === 1'b1 && topValidOut === 1'b0 && errCodeOut === mon_e.code)) begin
            errors++;
            $display("FAIL msg%0d_err got err=%0b top=%0b code=%0d want err code=%0d",
                     mon_e.id, errValidOut, topValidOut, errCodeOut, mon_e.code);
          end
        end else begin
          if (!(topValidOut === 1'b1 && errValidOut === 1'b0 && topLocateOut === mon_e.loc &&
                topBuyPriceOut === mon_e.bp && topBuySharesOut === mon_e.bs &&
                topSellPriceOut === mon_e.sp && topSellSharesOut === mon_e.ss)) begin
            errors++;
            $display("FAIL msg%0d_pub got top=%0b err=%0b loc=%0d bid=%0d/%0d ask=%0d/%0d want loc=%0d bid=%0d/%0d ask=%0d/%0d",
                     mon_e.id, topValidOut, errValidOut, topLocateOut, topBuyPriceOut,
                     topBuySharesOut, topSellPriceOut, topSellSharesOut,
                     mon_e.loc, mon_e.bp, mon_e.bs, mon_e.sp, mon_e.ss);
          end
        end
        checks++;
        if (cyc != mon_e.at) begin
          errors++;
          $display("FAIL msg%0d_timing got cycle %0d want cycle %0d", mon_e.id, cyc, mon_e.at);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, req);
    end
  endtask

  // Issues one message when the DUT is ready; has=1 queues the expected response.
  task automatic send(input int kind, input logic [63:0] r, input logic [15:0] l,
                      input logic [31:0] p, input logic [31:0] s, input logic bs,
                      input bit has, input exp_t e);
    int n;
    int lat;
    n = 0;
    while (readyOut !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (readyOut !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got readyOut=%b want 1", readyOut);
    end else begin
      addValidIn  = (kind == ADD || kind == ADDDEL);
      delValidIn  = (kind == DEL || kind == ADDDEL);
      execValidIn = (kind == EXE);
      refNumIn = r; locateIn = l; priceIn = p; sharesIn = s; buySellIn = bs;
      if (has) begin
        if (!e.isErr)                            lat = 11;
        else if (e.code == 3'd3 || e.code == 3'd4) lat = 1;
        else if (e.code == 3'd2)                 lat = 7;
        else                                     lat = 2;
        next_id++;
        e.id = next_id;
        e.at = cyc + lat;
        q.push_back(e);
      end
      @(posedge clk); #1;
      addValidIn = 1'b0; delValidIn = 1'b0; execValidIn = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
      q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  exp_t none;

  initial begin
    none = erx(3'd0);
    rstIn = 1'b1;
    addValidIn = 1'b0; delValidIn = 1'b0; execValidIn = 1'b0;
    refNumIn = '0; locateIn = '0; priceIn = '0; sharesIn = '0; buySellIn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstIn = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'd0, readyOut}, 64'd1);
    chk("rst_topvalid", {63'd0, topValidOut}, 64'd0);
    chk("rst_errvalid", {63'd0, errValidOut}, 64'd0);
    chk("rst_topfields", {topBuyPriceOut, topSellSharesOut} | {48'd0, topLocateOut}, 64'd0);
    chk("rst_errcode", {61'd0, errCodeOut}, 64'd0);
    @(posedge clk); #1;

    // Bid aggregation and delete on loc 1
    send(ADD, 5, 1, 100, 10, 1'b1, 1'b1, pub(1, 100, 10, 0, 0));
    send(ADD, 6, 1, 101, 3, 1'b1, 1'b1, pub(1, 101, 3, 0, 0));
    send(ADD, 7, 1, 100, 4, 1'b1, 1'b1, pub(1, 101, 3, 0, 0));
    // A strobe while busy must be dropped silently
    addValidIn = 1'b1; refNumIn = 40; locateIn = 1; priceIn = 999; sharesIn = 1; buySellIn = 1'b1;
    @(posedge clk); #1;
    addValidIn = 1'b0;
`ifdef MULTI_BOOK_STATS_EN
    chk("stats_dropped", {32'd0, droppedCountOut}, 64'd1);
`endif
    send(DEL, 6, 1, 0, 0, 1'b0, 1'b1, pub(1, 100, 14, 0, 0));

    // Sell side with over-sized execution, then exec on a dead order
    send(ADD, 9, 2, 50, 20, 1'b0, 1'b1, pub(2, 0, 0, 50, 20));
    send(EXE, 9, 2, 0, 25, 1'b0, 1'b1, pub(2, 0, 0, 0, 0));
    send(EXE, 9, 2, 0, 1, 1'b0, 1'b1, erx(3'd1));

    // Fill all four buy levels of loc 0, fifth distinct price is rejected
    send(ADD, 10, 0, 200, 1, 1'b1, 1'b1, pub(0, 200, 1, 0, 0));
    send(ADD, 11, 0, 201, 2, 1'b1, 1'b1, pub(0, 201, 2, 0, 0));
    send(ADD, 12, 0, 202, 3, 1'b1, 1'b1, pub(0, 202, 3, 0, 0));
    send(ADD, 13, 0, 203, 4, 1'b1, 1'b1, pub(0, 203, 4, 0, 0));
    send(ADD, 14, 0, 204, 5, 1'b1, 1'b1, erx(3'd2));
    send(ADD, 15, 0, 203, 6, 1'b1, 1'b1, pub(0, 203, 10, 0, 0));
    send(DEL, 14, 0, 0, 0, 1'b0, 1'b1, erx(3'd1));
    send(ADD, 16, 0, 300, 10, 1'b0, 1'b1, pub(0, 203, 10, 300, 10));
    send(EXE, 16, 0, 0, 4, 1'b0, 1'b1, pub(0, 203, 10, 300, 6));

    // Accept-time and lookup errors
    send(ADD, 50, 7, 1, 1, 1'b1, 1'b1, erx(3'd3));
    send(ADDDEL, 51, 1, 1, 1, 1'b1, 1'b1, erx(3'd4));
    send(ADD, 69, 1, 555, 1, 1'b1, 1'b1, erx(3'd5));
    // ref 5 survived the duplicate add: 14 - 3 at price 100
    send(EXE, 5, 1, 0, 3, 1'b1, 1'b1, pub(1, 100, 11, 0, 0));
    drain();

    // Reset in the cycle after accept aborts the message
    send(ADD, 20, 3, 10, 1, 1'b1, 1'b0, none);
    rstIn = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstIn = 1'b0;
    chk("midrst_ready", {63'd0, readyOut}, 64'd1);
    chk("midrst_topbid", {32'd0, topBuyPriceOut}, 64'd0);
    repeat (15) @(posedge clk);
    #1;
    send(DEL, 20, 3, 0, 0, 1'b0, 1'b1, erx(3'd1));
    send(DEL, 5, 1, 0, 0, 1'b0, 1'b1, erx(3'd1));
    send(ADD, 21, 3, 77, 7, 1'b0, 1'b1, pub(3, 0, 0, 77, 7));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
